// File: rtl/b10_seq_pkg.sv
// Shared types and command-word field layout for the b10 stimulus sequencer.
package b10_seq_pkg;

  typedef enum logic [1:0] {
    OP_APPLY    = 2'b00,
    OP_WAIT_CTS = 2'b01,
    OP_WAIT_CTR = 2'b10,
    OP_HALT     = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StRdwait,
    StExec,
    StWaiths,
    StDone
  } state_e;

  localparam int unsigned R_BTN   = 0;
  localparam int unsigned G_BTN   = 1;
  localparam int unsigned KEY     = 2;
  localparam int unsigned START   = 3;
  localparam int unsigned TEST    = 4;
  localparam int unsigned RTS     = 5;
  localparam int unsigned RTR     = 6;
  localparam int unsigned VIN_LSB = 7;
  localparam int unsigned VIN_MSB = 10;
  localparam int unsigned OBS     = 11;

  localparam int unsigned STIM_W  = 12;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned REP_LSB = 14;

  function automatic logic is_busy(state_e s);
    return s inside {StFetch, StRdwait, StExec, StWaiths};
  endfunction

endpackage

// File: rtl/b10_seq_wait_timer.sv
// Loadable down-counter with a terminal flag; shared by the rep hold and handshake timeout.
module b10_seq_wait_timer #(
  parameter int unsigned Width = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/b10_stim_sequencer.sv
// Fetches command words from program RAM and drives registered b10 stimulus,
// with per-word hold, cts/ctr handshake waits (with timeout) and halt.
module b10_stim_sequencer
  import b10_seq_pkg::*;
#(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned LAST_ADDR = 30,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_rdata,
  input  logic              cts,
  input  logic              ctr,
  output logic              r_button,
  output logic              g_button,
  output logic              key,
  output logic              start,
  output logic              test,
  output logic              rts,
  output logic              rtr,
  output logic [3:0]        v_in,
  output logic              obs,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] pc
);

  // Timer must hold both a 2-bit rep and TIMEOUT-1.
  localparam int unsigned       TimerW   = ($clog2(TIMEOUT) > 2) ? $clog2(TIMEOUT) : 2;
  localparam logic [ADDR_W-1:0] LastPc   = ADDR_W'(LAST_ADDR);
  localparam logic [TimerW-1:0] WaitLoad = TimerW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [STIM_W-1:0]   stim_q, stim_d;
  op_e                 op_q, op_d;
  logic                err_q, err_d;
  logic                tmr_load, tmr_dec, tmr_zero;
  logic [TimerW-1:0]   tmr_value;
  logic                advance, hs;

  b10_seq_wait_timer #(
    .Width (TimerW)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .dec        (tmr_dec),
    .zero       (tmr_zero)
  );

  assign hs = (op_q == OP_WAIT_CTS) ? cts : ctr;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    stim_d    = stim_q;
    op_d      = op_q;
    err_d     = err_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_value = '0;
    advance   = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (go) begin
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StRdwait;
      StRdwait: begin
        stim_d    = mem_rdata[STIM_W-1:0];
        op_d      = op_e'(mem_rdata[OP_LSB +: 2]);
        tmr_load  = 1'b1;
        tmr_value = TimerW'(mem_rdata[REP_LSB +: 2]);
        state_d   = StExec;
      end
      StExec: begin
        unique case (op_q)
          OP_APPLY: begin
            if (tmr_zero) advance = 1'b1;
            else          tmr_dec = 1'b1;
          end
          OP_WAIT_CTS, OP_WAIT_CTR: begin
            tmr_load  = 1'b1;
            tmr_value = WaitLoad;
            state_d   = StWaiths;
          end
          OP_HALT: state_d = StDone;
        endcase
      end
      StWaiths: begin
        if (hs) begin
          advance = 1'b1;
        end else if (tmr_zero) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // No wrap past the last program word; pc stays on it.
    if (advance) begin
      if (pc_q == LastPc) begin
        state_d = StDone;
      end else begin
        pc_d    = pc_q + 1'b1;
        state_d = StFetch;
      end
    end

    if (abort) begin
      state_d = StIdle;
      stim_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      stim_q  <= '0;
      op_q    <= OP_APPLY;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stim_q  <= stim_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr    = pc_q;
  assign mem_rd      = (state_q == StFetch);
  assign pc          = pc_q;
  assign busy        = is_busy(state_q);
  assign done        = (state_q == StDone);
  assign timeout_err = err_q;

  assign r_button = stim_q[R_BTN];
  assign g_button = stim_q[G_BTN];
  assign key      = stim_q[KEY];
  assign start    = stim_q[START];
  assign test     = stim_q[TEST];
  assign rts      = stim_q[RTS];
  assign rtr      = stim_q[RTR];
  assign v_in     = stim_q[VIN_MSB:VIN_LSB];
  assign obs      = stim_q[OBS];

endmodule
